// File: rtl/mem_hit_ctrl_if.sv
// Bundle of CPU-side request/response and RAM-side signals for mem_hit_ctrl.
// The slave modport is the controller's view; master is the requester/RAM side.
interface mem_hit_ctrl_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] imemload;
  logic [31:0] dmemload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        mem_err;

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  ramload, ramstate,
    output ihit, dhit, imemload, dmemload,
    output ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    output ramload, ramstate,
    input  ihit, dhit, imemload, dmemload,
    input  ramREN, ramWEN, ramaddr, ramstore, mem_err
  );
endinterface

// File: rtl/mem_hit_ctrl.sv
// Arbitrates instruction and data requests onto a single RAM port, issuing one-cycle
// hit pulses on completion and a sticky error on RAM error or access timeout.
module mem_hit_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        nRST,
  mem_hit_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, DREQ, IREQ, RESP, ERR} state_t;
  typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ram_state_t;

  state_t          state, next_state;
  logic [31:0]     d_addr, d_store, i_addr;
  logic            d_wen;
  logic [CW-1:0]   wait_cnt;
  logic            ihit_q, dhit_q, err_q;
  logic [31:0]     iload_q, dload_q;
  logic            waiting, access, ram_fail;

  always_comb begin
    next_state = state;
    waiting    = (state == DREQ) || (state == IREQ);
    access     = waiting && (bus.ramstate == RAM_ACCESS);
    // ACCESS on the last allowed cycle still completes rather than timing out
    ram_fail   = waiting && ((bus.ramstate == RAM_ERROR) ||
                             (!access && (wait_cnt == CW'(TIMEOUT - 1))));
    unique case (state)
      IDLE: begin
        if (bus.dmemREN || bus.dmemWEN) next_state = DREQ;
        else if (bus.imemREN)           next_state = IREQ;
      end
      DREQ, IREQ: begin
        if (ram_fail)    next_state = ERR;
        else if (access) next_state = RESP;
      end
      RESP:    next_state = IDLE;
      ERR:     next_state = ERR;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (state)
      DREQ: begin
        bus.ramaddr  = d_addr;
        bus.ramstore = d_store;
        bus.ramWEN   = d_wen;
        bus.ramREN   = !d_wen;
      end
      IREQ: begin
        bus.ramaddr = i_addr;
        bus.ramREN  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= IDLE;
      d_addr   <= '0;
      d_store  <= '0;
      d_wen    <= 1'b0;
      i_addr   <= '0;
      wait_cnt <= '0;
      ihit_q   <= 1'b0;
      dhit_q   <= 1'b0;
      err_q    <= 1'b0;
      iload_q  <= '0;
      dload_q  <= '0;
    end else begin
      state  <= next_state;
      ihit_q <= access && (state == IREQ) && !ram_fail;
      dhit_q <= access && (state == DREQ) && !ram_fail;
      if (next_state == ERR) err_q <= 1'b1;

      if (state == IDLE) begin
        wait_cnt <= '0;
        if (next_state == DREQ) begin
          d_addr  <= bus.dmemaddr;
          d_store <= bus.dmemstore;
          d_wen   <= bus.dmemWEN;
        end else if (next_state == IREQ) begin
          i_addr <= bus.imemaddr;
        end
      end else if (waiting) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (access && (state == IREQ))           iload_q <= bus.ramload;
      if (access && (state == DREQ) && !d_wen) dload_q <= bus.ramload;
    end
  end

  assign bus.ihit     = ihit_q;
  assign bus.dhit     = dhit_q;
  assign bus.imemload = iload_q;
  assign bus.dmemload = dload_q;
  assign bus.mem_err  = err_q;

endmodule

// File: tb/tb_mem_hit_ctrl.sv
// Directed bench for mem_hit_ctrl: a stimulus thread queues expected responses,
// a negedge monitor checks RAM strobes and hit pulses against the queue.
module tb_mem_hit_ctrl;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  mem_hit_ctrl_if bus ();

  mem_hit_ctrl #(.TIMEOUT(15)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  // RAM model: mode 0 normal (ACCESS after busy_cycles), 1 hang (BUSY), 2 error
  int unsigned ram_mode;
  int unsigned busy_cycles;
  int unsigned ram_cnt;
  logic strobe;
  assign strobe = bus.ramREN | bus.ramWEN;

  always @(posedge CLK) ram_cnt <= strobe ? ram_cnt + 1 : 0;

  always_comb begin
    bus.ramstate = 2'd0;
    if (strobe) begin
      if (ram_mode == 2)                 bus.ramstate = 2'd3;
      else if (ram_mode == 1)            bus.ramstate = 2'd1;
      else if (ram_cnt >= busy_cycles)   bus.ramstate = 2'd2;
      else                               bus.ramstate = 2'd1;
    end
  end

  assign bus.ramload = (bus.ramaddr == 32'h0000_0040) ? 32'h8C22_0004
                                                      : (bus.ramaddr ^ 32'h5A5A_0000);

  typedef struct {
    logic        is_d;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic is_d, input logic wen, input logic [31:0] addr,
                          input logic [31:0] store, input logic [31:0] load);
    exp_t e;
    e.is_d = is_d; e.wen = wen; e.addr = addr; e.store = store; e.load = load;
    sbq.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (nRST) begin
      if (strobe && sbq.size() > 0) begin
        chk("ramaddr", bus.ramaddr, sbq[0].addr);
        chk("ramWEN", {31'd0, bus.ramWEN}, {31'd0, sbq[0].wen});
        chk("ramREN", {31'd0, bus.ramREN}, {31'd0, !sbq[0].wen});
        if (sbq[0].is_d) chk("ramstore", bus.ramstore, sbq[0].store);
      end
      if (bus.ihit || bus.dhit) begin
        if (sbq.size() == 0) begin
          chk("unexpected_hit", {30'd0, bus.ihit, bus.dhit}, 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("hit_kind", {30'd0, bus.ihit, bus.dhit}, mon_e.is_d ? 32'd1 : 32'd2);
          if (mon_e.is_d) chk("dmemload", bus.dmemload, mon_e.load);
          else            chk("imemload", bus.imemload, mon_e.load);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clear_inputs();
    bus.imemREN = 1'b0; bus.imemaddr = '0;
    bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0;
    bus.dmemaddr = '0;  bus.dmemstore = '0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    clear_inputs();
    tick(2);
    nRST = 1'b1;
  endtask

  // Holds requests until their hit arrives, bounded by a cycle budget
  task automatic serve(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CLK);
      if (bus.dhit) begin bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0; end
      if (bus.ihit) bus.imemREN = 1'b0;
      if (!bus.dmemREN && !bus.dmemWEN && !bus.imemREN && sbq.size() == 0) done = 1'b1;
    end
    if (!done) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
      sbq.delete();
      clear_inputs();
    end
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ram_mode = 0; busy_cycles = 1;
    do_reset();
    chk("rst_ihit", {31'd0, bus.ihit}, 32'd0);
    chk("rst_dhit", {31'd0, bus.dhit}, 32'd0);
    chk("rst_mem_err", {31'd0, bus.mem_err}, 32'd0);
    chk("rst_imemload", bus.imemload, 32'd0);
    chk("rst_dmemload", bus.dmemload, 32'd0);
    chk("rst_strobes", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);

    // Instruction fetch
    push_exp(1'b0, 1'b0, 32'h40, 32'h0, 32'h8C22_0004);
    bus.imemREN = 1'b1; bus.imemaddr = 32'h40;
    serve("fetch");

    // Simultaneous data and instruction: data first
    push_exp(1'b1, 1'b0, 32'h100, 32'h0, 32'h5A5A_0100);
    push_exp(1'b0, 1'b0, 32'h44, 32'h0, 32'h5A5A_0044);
    bus.imemREN = 1'b1; bus.imemaddr = 32'h44;
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h100; bus.dmemstore = 32'h0;
    serve("priority");

    // Store leaves dmemload untouched
    push_exp(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 32'h5A5A_0100);
    bus.dmemWEN = 1'b1; bus.dmemaddr = 32'h200; bus.dmemstore = 32'hDEAD_BEEF;
    serve("store");

    // Five BUSY cycles; inputs change after latching and must be ignored
    busy_cycles = 5;
    push_exp(1'b1, 1'b0, 32'h180, 32'hCAFE_0000, 32'h5A5A_0180);
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h180; bus.dmemstore = 32'hCAFE_0000;
    tick(1);
    bus.dmemaddr = 32'hFFFF_0000; bus.dmemstore = 32'h1111_1111;
    serve("wait_states");
    chk("wait_mem_err", {31'd0, bus.mem_err}, 32'd0);
    busy_cycles = 1;

    // Read and write both asserted: write wins
    push_exp(1'b1, 1'b1, 32'h204, 32'h1234_5678, 32'h5A5A_0180);
    bus.dmemREN = 1'b1; bus.dmemWEN = 1'b1; bus.dmemaddr = 32'h204; bus.dmemstore = 32'h1234_5678;
    serve("rd_wr_both");

    // Timeout with RAM held BUSY
    ram_mode = 1;
    bus.imemREN = 1'b1; bus.imemaddr = 32'h80;
    tick(1);
    bus.imemREN = 1'b0;
    tick(14);
    chk("to_err_early", {31'd0, bus.mem_err}, 32'd0);
    chk("to_ramREN_wait", {31'd0, bus.ramREN}, 32'd1);
    chk("to_ramaddr_wait", bus.ramaddr, 32'h80);
    tick(1);
    chk("to_mem_err", {31'd0, bus.mem_err}, 32'd1);
    chk("to_strobes_off", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
    chk("to_ramaddr_off", bus.ramaddr, 32'd0);
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h300;
    tick(3);
    chk("err_ignores_req", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
    chk("err_sticky", {31'd0, bus.mem_err}, 32'd1);
    chk("err_no_hit", {30'd0, bus.ihit, bus.dhit}, 32'd0);
    do_reset();
    chk("err_cleared", {31'd0, bus.mem_err}, 32'd0);

    // RAM ERROR status goes straight to ERR
    ram_mode = 2;
    bus.dmemWEN = 1'b1; bus.dmemaddr = 32'h208; bus.dmemstore = 32'h1;
    tick(1);
    chk("rerr_ramWEN", {31'd0, bus.ramWEN}, 32'd1);
    bus.dmemWEN = 1'b0;
    tick(1);
    chk("rerr_mem_err", {31'd0, bus.mem_err}, 32'd1);
    chk("rerr_strobes", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
    do_reset();

    // Reset in the middle of a data access
    ram_mode = 1;
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h300;
    tick(1);
    chk("mid_ramREN", {31'd0, bus.ramREN}, 32'd1);
    chk("mid_ramaddr", bus.ramaddr, 32'h300);
    nRST = 1'b0; bus.dmemREN = 1'b0;
    tick(1);
    chk("mid_strobes", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
    chk("mid_ramaddr_rst", bus.ramaddr, 32'd0);
    chk("mid_hits", {30'd0, bus.ihit, bus.dhit}, 32'd0);
    chk("mid_dmemload", bus.dmemload, 32'd0);
    chk("mid_imemload", bus.imemload, 32'd0);
    chk("mid_mem_err", {31'd0, bus.mem_err}, 32'd0);
    nRST = 1'b1; ram_mode = 0;
    tick(6);
    chk("mid_idle_after", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_hit_ctrl.md
MEM_HIT_CTRL -- requirements
Module: mem_hit_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the maximum cycles waited for a RAM ACCESS before declaring an error.
REQ-002 SHALL have port CLK  input  1  system clock; every state change happens on the rising edge.
REQ-003 SHALL have port nRST  input  1  reset, synchronous and active-low, sampled on the rising edge of CLK.
REQ-004 SHALL have port imemREN  input  1  instruction fetch request.
REQ-005 SHALL have port imemaddr  input  32  instruction fetch address.
REQ-006 SHALL have port dmemREN  input  1  data load request.
REQ-007 SHALL have port dmemWEN  input  1  data store request.
REQ-008 SHALL have port dmemaddr  input  32  data address.
REQ-009 SHALL have port dmemstore  input  32  store data.
REQ-010 SHALL have port ihit  output  1  instruction response pulse, consumed by the hazard unit.
REQ-011 SHALL have port dhit  output  1  data response pulse, consumed by the hazard unit.
REQ-012 SHALL have port imemload  output  32  fetched instruction word.
REQ-013 SHALL have port dmemload  output  32  loaded data word.
REQ-014 SHALL have port ramREN  output  1  RAM read strobe.
REQ-015 SHALL have port ramWEN  output  1  RAM write strobe.
REQ-016 SHALL have port ramaddr  output  32  RAM address.
REQ-017 SHALL have port ramstore  output  32  RAM write data.
REQ-018 SHALL have port ramload  input  32  RAM read data.
REQ-019 SHALL have port ramstate  input  2  RAM status, encoded FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-020 SHALL have port mem_err  output  1  sticky error flag.

Function
REQ-021 SHALL implement the FSM states IDLE, DREQ, IREQ, RESP and ERR.
REQ-022 In IDLE, if dmemREN or dmemWEN is high, the next state SHALL be DREQ, and the block SHALL latch dmemaddr, dmemstore and the write flag (dmemWEN; dmemWEN wins if both dmemREN and dmemWEN are high).
REQ-023 In IDLE, if there is no data request and imemREN is high, the next state SHALL be IREQ and the block SHALL latch imemaddr.
REQ-024 Data requests SHALL take priority over instruction requests whenever both are sampled in the same cycle.
REQ-025 In DREQ, ramaddr SHALL equal the latched data address, ramstore the latched store data, ramWEN the latched write flag and ramREN its inverse.
REQ-026 In IREQ, ramaddr SHALL equal the latched instruction address, ramREN SHALL be 1 and ramWEN SHALL be 0.
REQ-027 In all other states, ramREN, ramWEN, ramaddr and ramstore SHALL be 0.
REQ-028 In DREQ or IREQ, a ramstate of ACCESS SHALL cause a transition to RESP on the next edge.
REQ-029 That same edge SHALL register ramload into dmemload (DREQ) or imemload (IREQ); for a store, dmemload SHALL be left unchanged.
REQ-030 In RESP, exactly one of dhit or ihit SHALL be 1, matching the access just completed, for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-031 ihit and dhit SHALL be registered, SHALL never both be high, and SHALL be 0 outside RESP.
REQ-032 Minimum latency: request sampled in IDLE at edge N, ACCESS present in the following cycle, hit high in the cycle after edge N+2.
REQ-033 The RESP cycle SHALL NOT sample new requests; the requester drops or advances its request on the hit.
REQ-034 A wait counter (width ceil(log2(TIMEOUT+1))) SHALL clear on entry to DREQ or IREQ and increment each cycle spent waiting.
REQ-035 If the wait counter reaches TIMEOUT without ACCESS, or ramstate equals ERROR, the next state SHALL be ERR.
REQ-036 ERR SHALL set mem_err=1, SHALL drive no RAM strobes, SHALL produce no hits, and SHALL be left only by reset.
REQ-037 ramstate values FREE or BUSY in DREQ or IREQ SHALL keep the current state and hold the latched address stable.
REQ-038 Request inputs changing during DREQ or IREQ SHALL NOT affect ramaddr or ramstore, which are taken from the latched values.

Reset
REQ-039 While nRST=0 at a rising edge, the state SHALL become IDLE and ihit, dhit, mem_err, imemload, dmemload and the wait counter SHALL all become 0.
REQ-040 A reset asserted mid-access SHALL abandon the access with no hit issued, and RAM strobes SHALL be 0 from the cycle after that edge.

Verification
REQ-041 Instruction fetch: imemREN=1, imemaddr=0x00000040, ACCESS one cycle after ramREN rises, ramload=0x8C220004 -> ihit high one cycle, imemload=0x8C220004, dhit=0.
REQ-042 Priority: imemREN=1 and dmemREN=1 sampled together, dmemaddr=0x00000100 -> DREQ first, then dhit, then the fetch served with ihit; ramaddr sequence 0x100 then imemaddr.
REQ-043 Store: dmemWEN=1, dmemaddr=0x00000200, dmemstore=0xDEADBEEF -> ramWEN=1, ramstore=0xDEADBEEF, dhit pulse, dmemload unchanged.
REQ-044 Wait states: BUSY for 5 cycles then ACCESS -> ramaddr stable throughout, hit exactly once, mem_err=0.
REQ-045 Timeout: TIMEOUT=15 with ramstate held BUSY -> mem_err=1 after 15 waiting cycles, no hits; the same holds immediately for ramstate=ERROR.
REQ-046 Reset mid-access: nRST=0 during DREQ -> next cycle IDLE, all outputs 0, no dhit emitted.
